// File: rtl/bram_fifo_pkg.sv
// Shared FIFO package: default data width / depth and a constant-foldable
// ceiling-log2 helper used to size RAM address ports.
package bram_fifo_pkg;

    localparam int unsigned FIFO_WIDTH      = 16;
    localparam int unsigned FIFO_DEPTH_LOG2 = 8;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_fifo_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port,
// single clock. The storage array has no reset; only the read register does.
// Ports:
//   clk, rst            clock and synchronous active-high reset (read reg only)
//   we, waddr, wdata    write port
//   re, raddr           read request; rdata loads on re, holds otherwise
//   rdata               registered read word (old data on same-address write)
module bram_sdp
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_fifo.sv
// Synchronous FIFO built on a simple dual-port block RAM.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             empties the FIFO; wr_en/rd_en ignored that cycle
//   wr_en, wr_data    write request and word
//   rd_en             read request
//   rd_data, rd_valid registered read word, valid one cycle after acceptance
//   full, empty, almost_full, almost_empty   level-derived status
//   level             stored word count (0..DEPTH)
//   overflow, underflow  sticky rejected-write / rejected-read flags
//   clr_err           clears the sticky flags unless a new error coincides
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = FIFO_WIDTH,
    parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int unsigned AFULL_LVL  = (1 << DEPTH_LOG2) - 4,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [LW-1:0] level_nxt;

    // Status flags straight from the registered level.
    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AFULL_LVL));
    assign almost_empty = (level <= LW'(AEMPTY_LVL));

    // Acceptance: a read needs stored data, so a write into an empty FIFO
    // cannot satisfy a same-cycle read; a write at full rides on a read.
    always_comb begin
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        level_nxt = level;
        if (!flush) begin
            rd_acc = rd_en && !empty;
            wr_acc = wr_en && (!full || rd_acc);
        end
        level_nxt = level + LW'(wr_acc) - LW'(rd_acc);
    end

    // Pointers, level, read-valid and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + AW'(1);
            end
            level     <= level_nxt;
            rd_valid  <= rd_acc;
            overflow  <= (wr_en && !wr_acc) || (overflow  && !clr_err);
            underflow <= (rd_en && !rd_acc) || (underflow && !clr_err);
        end
    end

    bram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_bram_fifo;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [8:0]  level;
    logic        overflow;
    logic        underflow;

    always #5 clk = ~clk;

    bram_fifo #(
        .WIDTH      (16),
        .DEPTH_LOG2 (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [15:0] mq [$];
    bit          m_rv;
    logic [15:0] m_rd;
    bit          m_ovf;
    bit          m_udf;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          wr;
        logic [15:0] wd;
        bit          rd;
        bit          clr;
        int          lvl;
        bit          rv;
        logic [15:0] rdd;
        bit          ovf;
        bit          udf;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue semantics, read judged on contents before the write.
    task automatic model_step();
        bit rd_ok;
        bit wr_ok;
        if (rst) begin
            mq.delete();
            m_rv = 0; m_rd = '0; m_ovf = 0; m_udf = 0;
        end else if (flush) begin
            mq.delete();
            m_rv = 0;
        end else begin
            rd_ok = rd_en && (mq.size() > 0);
            wr_ok = wr_en && ((mq.size() < DEPTH) || rd_ok);
            m_rv  = rd_ok;
            if (rd_ok) m_rd = mq.pop_front();
            if (wr_ok) mq.push_back(wr_data);
            m_ovf = (wr_en && !wr_ok) || (m_ovf && !clr_err);
            m_udf = (rd_en && !rd_ok) || (m_udf && !clr_err);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".level"},    32'(level),        32'(n));
        chk({tag, ".empty"},    32'(empty),        32'(n == 0));
        chk({tag, ".full"},     32'(full),         32'(n == DEPTH));
        chk({tag, ".afull"},    32'(almost_full),  32'(n >= DEPTH - 4));
        chk({tag, ".aempty"},   32'(almost_empty), 32'(n <= 4));
        chk({tag, ".rd_valid"}, 32'(rd_valid),     32'(m_rv));
        chk({tag, ".rd_data"},  32'(rd_data),      32'(m_rd));
        chk({tag, ".overflow"}, 32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},32'(underflow),    32'(m_udf));
    endtask

    task automatic step(input string tag, input bit r, input bit fl, input bit w,
                        input logic [15:0] d, input bit rd, input bit ce);
        rst = r; flush = fl; wr_en = w; wr_data = d; rd_en = rd; clr_err = ce;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic fill(input string tag, input int n, input int base);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 1, 16'(base + i), 0, 0);
    endtask

    initial begin
        // rst, flush, wr, wd, rd, clr | lvl, rv, rdd, ovf, udf
        tbl[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[1]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};
        tbl[2]  = '{0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0};
        tbl[3]  = '{0, 0, 1, 16'h1111, 1, 0, 1, 0, 16'h0000, 0, 1};
        tbl[4]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h1111, 0, 1};
        tbl[5]  = '{0, 0, 1, 16'h2222, 0, 0, 1, 0, 16'h1111, 0, 1};
        tbl[6]  = '{0, 0, 1, 16'h3333, 0, 1, 2, 0, 16'h1111, 0, 0};
        tbl[7]  = '{0, 0, 0, 16'h0000, 1, 0, 1, 1, 16'h2222, 0, 0};
        tbl[8]  = '{0, 1, 1, 16'h4444, 1, 0, 0, 0, 16'h2222, 0, 0};
        tbl[9]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h2222, 0, 1};
        tbl[10] = '{0, 0, 1, 16'h5555, 0, 1, 1, 0, 16'h2222, 0, 0};
        tbl[11] = '{0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h5555, 0, 0};
        tbl[12] = '{0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h5555, 0, 1};

        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].flush, tbl[i].wr,
                 tbl[i].wd, tbl[i].rd, tbl[i].clr);
            chk($sformatf("vec%0d.level", i),    32'(level),     32'(tbl[i].lvl));
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid),  32'(tbl[i].rv));
            chk($sformatf("vec%0d.rd_data", i),  32'(rd_data),   32'(tbl[i].rdd));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow),  32'(tbl[i].ovf));
            chk($sformatf("vec%0d.underflow", i),32'(underflow), 32'(tbl[i].udf));
        end

        // Full fill and in-order drain with threshold boundaries.
        step("seq1.rst", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 256; i++) begin
            step("seq1.wr", 0, 0, 1, 16'(i), 0, 0);
            if (i == 4)   chk("seq1.aempty_at4",   32'(almost_empty), 32'd1);
            if (i == 5)   chk("seq1.aempty_at5",   32'(almost_empty), 32'd0);
            if (i == 251) chk("seq1.afull_at251",  32'(almost_full),  32'd0);
            if (i == 252) chk("seq1.afull_at252",  32'(almost_full),  32'd1);
            if (i == 255) chk("seq1.full_at255",   32'(full),         32'd0);
            if (i == 256) chk("seq1.full_at256",   32'(full),         32'd1);
        end
        for (int i = 1; i <= 256; i++) begin
            step("seq1.rd", 0, 0, 0, 0, 1, 0);
            chk("seq1.rd_valid", 32'(rd_valid), 32'd1);
            chk("seq1.rd_data",  32'(rd_data),  32'(i));
        end
        chk("seq1.empty_end", 32'(empty), 32'd1);
        step("seq1.idle", 0, 0, 0, 0, 0, 0);
        chk("seq1.rv_idle", 32'(rd_valid), 32'd0);

        // Overflow at full, then clear.
        step("seq2.rst", 1, 0, 0, 0, 0, 0);
        fill("seq2.fill", 256, 1);
        step("seq2.ovf", 0, 0, 1, 16'hDEAD, 0, 0);
        chk("seq2.overflow", 32'(overflow), 32'd1);
        chk("seq2.level",    32'(level),    32'd256);
        step("seq2.clr", 0, 0, 0, 0, 0, 1);
        chk("seq2.ovf_clr",  32'(overflow), 32'd0);

        // Simultaneous write+read at full; then drain everything.
        for (int n = 0; n < 10; n++) begin
            step("seq3.wrrd", 0, 0, 1, 16'hA000 + 16'(n), 1, 0);
            chk("seq3.rd_data",  32'(rd_data),  32'(n + 1));
            chk("seq3.level",    32'(level),    32'd256);
            chk("seq3.overflow", 32'(overflow), 32'd0);
        end
        for (int i = 0; i < 256; i++) step("seq3.drain", 0, 0, 0, 0, 1, 0);
        chk("seq3.last", 32'(rd_data), 32'h0000A009);

        // Write+read on empty: read rejected, written word readable next.
        step("seq4.rst", 1, 0, 0, 0, 0, 0);
        step("seq4.wrrd", 0, 0, 1, 16'h1234, 1, 0);
        chk("seq4.underflow", 32'(underflow), 32'd1);
        chk("seq4.level",     32'(level),     32'd1);
        chk("seq4.rd_valid",  32'(rd_valid),  32'd0);
        step("seq4.rd", 0, 0, 0, 0, 1, 0);
        chk("seq4.rd_data",   32'(rd_data),   32'h1234);
        chk("seq4.rv",        32'(rd_valid),  32'd1);

        // Flush then read.
        step("seq5.rst", 1, 0, 0, 0, 0, 0);
        fill("seq5.fill", 5, 16'h0700);
        step("seq5.flush", 0, 1, 0, 0, 0, 0);
        step("seq5.rd", 0, 0, 0, 0, 1, 0);
        chk("seq5.level",     32'(level),     32'd0);
        chk("seq5.empty",     32'(empty),     32'd1);
        chk("seq5.underflow", 32'(underflow), 32'd1);
        chk("seq5.rd_valid",  32'(rd_valid),  32'd0);

        // Reset coincident with a read discards it and clears flags.
        step("seq6.rd0", 0, 0, 0, 0, 1, 0);
        fill("seq6.fill", 3, 16'h0900);
        step("seq6.rst", 1, 0, 0, 0, 1, 0);
        chk("seq6.level",     32'(level),        32'd0);
        chk("seq6.rd_valid",  32'(rd_valid),     32'd0);
        chk("seq6.rd_data",   32'(rd_data),      32'd0);
        chk("seq6.underflow", 32'(underflow),    32'd0);
        chk("seq6.empty",     32'(empty),        32'd1);
        chk("seq6.aempty",    32'(almost_empty), 32'd1);
        chk("seq6.full",      32'(full),         32'd0);
        chk("seq6.afull",     32'(almost_full),  32'd0);
        step("seq6.idle", 0, 0, 0, 0, 0, 0);
        chk("seq6.rv_after",  32'(rd_valid),     32'd0);

        // Random traffic in alternating fill/drain phases.
        for (int c = 0; c < 3200; c++) begin
            bit ph;
            bit w, r, f, ce, rs;
            ph = ((c / 400) % 2) == 0;
            w  = ($urandom_range(99) < (ph ? 85 : 15));
            r  = ($urandom_range(99) < (ph ? 15 : 85));
            f  = ($urandom_range(399) == 0);
            ce = ($urandom_range(19) == 0);
            rs = ($urandom_range(999) == 0);
            step("rand", rs, f, w, 16'($urandom), r, ce);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
